// File: rtl/mux_arb_pkg.sv
// Shared definitions for the arbitrating N-to-1 mux: arbitration mode
// encoding and a clog2 helper that never returns zero, so a channel index
// port is always at least one bit wide.
package mux_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Bits needed to hold a channel index; at least 1 even for tiny counts.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/arb_rr_nto1.sv
// N-input arbiter: fixed priority (lowest index wins) or round-robin with a
// rotating start pointer. Grant is combinational from req and the pointer;
// the pointer advances past the winner only when the caller signals that
// the grant was actually taken (en).
module arb_rr_nto1
  import mux_arb_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int RR_MODE = 1,
  localparam int CH_BITS = clog2_min1(NUM_CH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_CH-1:0]  req,
  input  logic               en,
  output logic [NUM_CH-1:0]  grant,
  output logic [CH_BITS-1:0] grant_idx
);

  localparam arb_mode_e MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  logic [CH_BITS-1:0] ptr_q;
  logic [CH_BITS-1:0] ptr_d;

  // Search from the start index upward with wrap; first requester wins.
  always_comb begin
    int  start;
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    start     = (MODE == ARB_RR) ? int'(ptr_q) : 0;
    idx       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = start + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = CH_BITS'(idx);
      end
    end
  end

  // Next pointer: one past the channel just served; fixed mode pins it at 0.
  always_comb begin
    int nxt;
    ptr_d = ptr_q;
    nxt   = 0;
    if (MODE == ARB_FIXED) begin
      ptr_d = '0;
    end else if (en) begin
      nxt = int'(grant_idx) + 1;
      if (nxt >= NUM_CH) nxt = 0;
      ptr_d = CH_BITS'(nxt);
    end
  end

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mux_rr_arb_nto1.sv
// NUM_CH-to-1 arbitrating mux with valid/ready on every port. The arbiter
// picks one requesting channel; its message lands in a single output
// register. The register accepts a new message whenever it is empty or
// being drained this cycle, giving one message per cycle at full rate.
module mux_rr_arb_nto1
  import mux_arb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_CH  = 4,
  parameter int RR_MODE = 1,
  localparam int CH_BITS = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_val,
  output logic [NUM_CH-1:0]        in_rdy,
  input  logic [NUM_CH*WIDTH-1:0]  in_msg,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [WIDTH-1:0]         out_msg,
  output logic [CH_BITS-1:0]       out_ch
);

  logic               out_val_q, out_val_d;
  logic [WIDTH-1:0]   out_msg_q, out_msg_d;
  logic [CH_BITS-1:0] out_ch_q,  out_ch_d;

  logic [NUM_CH-1:0]  grant;
  logic [CH_BITS-1:0] grant_idx;
  logic               accept;
  logic               in_xfer;
  logic [WIDTH-1:0]   sel_msg;
  logic [WIDTH-1:0]   masked_msg [NUM_CH];

  arb_rr_nto1 #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_val),
    .en        (in_xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Ready depends only on valids, the register state and out_rdy -- never
  // on message data -- and is forced low while reset is held.
  assign accept  = !out_val_q || out_rdy;
  assign in_rdy  = (accept && reset) ? grant : '0;
  assign in_xfer = |in_rdy;

  // One-hot AND-OR data select: each channel contributes only when granted.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
    assign masked_msg[gi] = grant[gi] ? in_msg[gi*WIDTH +: WIDTH] : '0;
  end

  // OR together the masked channels to form the selected message.
  always_comb begin
    sel_msg = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_msg = sel_msg | masked_msg[k];
    end
  end

  // Output register next state: load on input transfer, clear valid on a
  // pure drain, otherwise hold (data and channel keep their last values).
  always_comb begin
    out_val_d = out_val_q;
    out_msg_d = out_msg_q;
    out_ch_d  = out_ch_q;
    if (in_xfer) begin
      out_val_d = 1'b1;
      out_msg_d = sel_msg;
      out_ch_d  = grant_idx;
    end else if (out_val_q && out_rdy) begin
      out_val_d = 1'b0;
    end
  end

  // Output pipeline register; a message held at reset is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      out_ch_q  <= '0;
    end else begin
      out_val_q <= out_val_d;
      out_msg_q <= out_msg_d;
      out_ch_q  <= out_ch_d;
    end
  end

  assign out_val = out_val_q;
  assign out_msg = out_msg_q;
  assign out_ch  = out_ch_q;

endmodule

// File: tb/tb_mux_rr_arb_nto1.sv
// Bench for mux_rr_arb_nto1: a round-robin and a fixed-priority instance
// share the same stimulus. A behavioural model (queue-free arithmetic over
// a pointer and a held message per instance) is checked every cycle, and
// directed scenarios pin the model with hand-computed values.
module tb_mux_rr_arb_nto1;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CB = 2;

  logic           clk   = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   in_val = '0;
  logic [N*W-1:0] in_msg = '0;
  logic           out_rdy = 1'b0;

  logic [N-1:0]   rdy_r, rdy_f;
  logic           val_r, val_f;
  logic [W-1:0]   msg_r, msg_f;
  logic [CB-1:0]  ch_r, ch_f;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_rr_arb_nto1 #(.WIDTH(W), .NUM_CH(N), .RR_MODE(1)) u_rr (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy_r), .in_msg(in_msg),
    .out_val(val_r), .out_rdy(out_rdy), .out_msg(msg_r), .out_ch(ch_r)
  );

  mux_rr_arb_nto1 #(.WIDTH(W), .NUM_CH(N), .RR_MODE(0)) u_fx (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy_f), .in_msg(in_msg),
    .out_val(val_f), .out_rdy(out_rdy), .out_msg(msg_f), .out_ch(ch_f)
  );

  // Model state; index 0 = round-robin instance, 1 = fixed-priority instance.
  bit         m_val [2] = '{0, 0};
  logic [W-1:0] m_msg [2] = '{8'h00, 8'h00};
  int         m_ch  [2] = '{0, 0};
  int         m_ptr [2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner for instance k: first valid channel scanning from its start point.
  function automatic int pick(input int k, input logic [N-1:0] v);
    int start;
    start = (k == 0) ? m_ptr[0] : 0;
    for (int j = 0; j < N; j++) begin
      if (v[(start + j) % N]) return (start + j) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rdy(input int k);
    int g;
    g = pick(k, in_val);
    if (!reset) return '0;
    if ((!m_val[k] || out_rdy) && g >= 0) return N'(1) << g;
    return '0;
  endfunction

  // Model update on each edge (or reset assertion), then output comparison.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_val[k] = 0; m_msg[k] = '0; m_ch[k] = 0; m_ptr[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int g;
        g = pick(k, in_val);
        if ((!m_val[k] || out_rdy) && g >= 0) begin
          m_val[k] = 1;
          m_msg[k] = in_msg[g*W +: W];
          m_ch[k]  = g;
          if (k == 0) m_ptr[0] = (g + 1) % N;
        end else if (m_val[k] && out_rdy) begin
          m_val[k] = 0;
        end
      end
    end
    #1;
    chk("rr_out_val", val_r, m_val[0]);
    chk("rr_out_msg", msg_r, m_msg[0]);
    chk("rr_out_ch",  ch_r,  m_ch[0]);
    chk("fx_out_val", val_f, m_val[1]);
    chk("fx_out_msg", msg_f, m_msg[1]);
    chk("fx_out_ch",  ch_f,  m_ch[1]);
  end

  // Ready is combinational; check it mid-cycle against the model's view.
  always @(negedge clk) begin
    chk("rr_in_rdy", rdy_r, exp_rdy(0));
    chk("fx_in_rdy", rdy_f, exp_rdy(1));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk("reset_out_val", val_r, 1'b0);
    chk("reset_in_rdy", rdy_r, 4'b0000);
    reset = 1'b1;

    // Load a message, then assert reset mid-cycle while it is held
    in_val = 4'b0100;
    in_msg[2*W +: W] = 8'hA5;
    step();
    chk("load_val", val_r, 1'b1);
    chk("load_msg", msg_r, 8'hA5);
    chk("load_ch",  ch_r,  2'd2);
    out_rdy = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_val", val_r, 1'b0);
    chk("async_rst_ch",  ch_r,  2'd0);
    chk("async_rst_rdy", rdy_r, 4'b0000);
    step();
    reset = 1'b1;
    step();
    chk("post_rst_val", val_r, 1'b1);
    chk("post_rst_msg", msg_r, 8'hA5);
    chk("post_rst_ch",  ch_r,  2'd2);

    // Round-robin fairness with all channels requesting
    rst_pulse();
    in_val = 4'b1111;
    for (int i = 0; i < N; i++) in_msg[i*W +: W] = 8'h10 + 8'(i);
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_fair_ch",  ch_r,  32'(i % 4));
      chk("rr_fair_msg", msg_r, 32'(8'h10 + i % 4));
      chk("fx_fair_ch",  ch_f,  2'd0);
    end

    // Fixed priority
    in_val = 4'b1110;
    step();
    step();
    chk("fx_prio_ch",  ch_f,  2'd1);
    chk("fx_prio_msg", msg_f, 8'h11);
    in_val = 4'b1100;
    step();
    chk("fx_prio_ch2", ch_f, 2'd2);

    // Backpressure: fill from ch3, stall, then resume with wrapped pointer
    rst_pulse();
    in_msg = '0;
    in_msg[3*W +: W] = 8'h3C;
    in_msg[0*W +: W] = 8'hA0;
    in_msg[1*W +: W] = 8'hA1;
    in_val = 4'b1000;
    out_rdy = 1'b1;
    step();
    chk("bp_fill_ch",  ch_r,  2'd3);
    chk("bp_fill_msg", msg_r, 8'h3C);
    out_rdy = 1'b0;
    in_val = 4'b0011;
    #1;
    chk("bp_stall_rdy", rdy_r, 4'b0000);
    repeat (3) begin
      step();
      chk("bp_hold_msg", msg_r, 8'h3C);
      chk("bp_hold_ch",  ch_r,  2'd3);
      chk("bp_hold_val", val_r, 1'b1);
    end
    out_rdy = 1'b1;
    #1;
    chk("bp_resume_rdy", rdy_r, 4'b0001);
    step();
    chk("bp_next_ch0", ch_r, 2'd0);
    chk("bp_next_msg0", msg_r, 8'hA0);
    step();
    chk("bp_next_ch1", ch_r, 2'd1);

    // Simultaneous drain and refill
    in_val = 4'b0010;
    in_msg[1*W +: W] = 8'h77;
    step();
    chk("simul_val", val_r, 1'b1);
    chk("simul_msg", msg_r, 8'h77);
    chk("simul_ch",  ch_r,  2'd1);

    // Idle drain, then a lone request on ch0
    in_val = 4'b0000;
    step();
    chk("drain_val", val_r, 1'b0);
    in_val = 4'b0001;
    in_msg[0*W +: W] = 8'h5A;
    #1;
    chk("lone_rdy", rdy_r, 4'b0001);
    step();
    chk("lone_val", val_r, 1'b1);
    chk("lone_ch",  ch_r,  2'd0);
    chk("lone_msg", msg_r, 8'h5A);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_val  = N'($urandom);
      in_msg  = {$urandom};
      out_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_pulse();
      end else begin
        step();
      end
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
